hack_mem_responder: RTL and testbench



---
 rtl/hack_mem_responder.sv | 130 +++++++++++++
 tb/tb_hack_mem_responder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_mem_responder.sv
// Memory side of the Hack CPU bus: program ROM filled over a load stream, data RAM,
// keyboard register, and the CPU reset sequencer (LOAD -> HOLD -> RUN).
module hack_mem_responder #(
    parameter int unsigned ROM_DEPTH   = 1024,
    parameter int unsigned RAM_DEPTH   = 2048,
    parameter int unsigned KBD_ADDR    = 24576,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    input  logic [14:0] pc,
    input  logic [14:0] addressM,
    input  logic [15:0] outM,
    input  logic        writeM,
    input  logic [15:0] kbd,
    output logic [15:0] instruction,
    output logic [15:0] inM,
    output logic        cpu_reset,
    output logic        running,
    output logic [15:0] load_count
);

    localparam int ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ROM_AW-1:0] ptr_reg, ptr_next;
    logic [15:0]       count_reg, count_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              accept;
    logic              rom_we;
    logic              ram_we;

    logic [15:0] rom [ROM_DEPTH];
    logic [15:0] ram [RAM_DEPTH];

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        hold_next  = hold_reg;
        load_ready = 1'b0;
        cpu_reset  = 1'b1;
        running    = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    accept     = 1'b1;
                    ptr_next   = ptr_reg + 1'b1;
                    count_next = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
                    // The last ROM slot ends the image even without load_last.
                    if (load_last || ptr_reg == ROM_AW'(ROM_DEPTH - 1)) begin
                        state_next = ST_HOLD;
                        hold_next  = HOLD_W'(HOLD_CYCLES);
                    end
                end
            end
            ST_HOLD: begin
                hold_next = hold_reg - HOLD_W'(1);
                if (hold_reg == HOLD_W'(1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                cpu_reset = 1'b0;
                running   = 1'b1;
            end
            default: state_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_LOAD;
            ptr_reg   <= '0;
            count_reg <= '0;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
            hold_reg  <= hold_next;
        end
    end

    // Reset overrides any write presented in the same cycle; contents survive reset.
    assign rom_we = accept && !reset;
    assign ram_we = (state_reg == ST_RUN) && writeM && !reset && (32'(addressM) < RAM_DEPTH);

    always_ff @(posedge clk) begin
        if (rom_we) begin
            rom[ptr_reg] <= load_data;
        end
        if (ram_we) begin
            ram[addressM[RAM_AW-1:0]] <= outM;
        end
    end

    always_comb begin
        instruction = 16'h0000;
        if (state_reg == ST_RUN && 32'(pc) < ROM_DEPTH) begin
            instruction = rom[pc[ROM_AW-1:0]];
        end
    end

    always_comb begin
        inM = 16'h0000;
        if (32'(addressM) < RAM_DEPTH) begin
            inM = ram[addressM[RAM_AW-1:0]];
        end else if (32'(addressM) == KBD_ADDR) begin
            inM = kbd;
        end
    end

    assign load_count = count_reg;

endmodule

// File: tb/tb_hack_mem_responder.sv
// Randomised and directed bench for hack_mem_responder, checked every cycle against
// a timing-level model (release time, ROM/RAM shadow arrays).
module tb_hack_mem_responder;

    localparam int ROM_D = 1024;
    localparam int RAM_D = 2048;
    localparam int KBD_A = 24576;
    localparam int HOLD  = 4;

    logic        clk = 1'b0;
    logic        reset, load_valid, load_last, writeM;
    logic [15:0] load_data, outM, kbd;
    logic [14:0] pc, addressM;
    logic        load_ready, cpu_reset, running;
    logic [15:0] instruction, inM, load_count;

    logic        reset4, load_valid4, load_last4;
    logic [15:0] load_data4;
    logic        load_ready4, cpu_reset4, running4;
    logic [15:0] instruction4, inM4, load_count4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hack_mem_responder dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .pc(pc), .addressM(addressM),
        .outM(outM), .writeM(writeM), .kbd(kbd), .instruction(instruction), .inM(inM),
        .cpu_reset(cpu_reset), .running(running), .load_count(load_count)
    );

    hack_mem_responder #(.ROM_DEPTH(4)) dut4 (
        .clk(clk), .reset(reset4), .load_valid(load_valid4), .load_data(load_data4),
        .load_last(load_last4), .load_ready(load_ready4), .pc(pc), .addressM(addressM),
        .outM(outM), .writeM(writeM), .kbd(kbd), .instruction(instruction4), .inM(inM4),
        .cpu_reset(cpu_reset4), .running(running4), .load_count(load_count4)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the CPU is released HOLD edges after the edge that accepted the final word.
    int          cyc = 0;
    bit          m_init = 1'b0;
    bit          m_loading = 1'b1;
    int          m_release = 0;
    int          m_ptr = 0;
    int          m_count = 0;
    logic [15:0] m_rom [ROM_D];
    bit          m_rom_v [ROM_D];
    logic [15:0] m_ram [RAM_D];
    bit          m_ram_v [RAM_D];

    function automatic bit model_running();
        return m_init && !m_loading && (cyc >= m_release);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_init    <= 1'b1;
            m_loading <= 1'b1;
            m_ptr     <= 0;
            m_count   <= 0;
        end else if (m_init) begin
            if (m_loading && load_valid) begin
                m_rom[m_ptr]   <= load_data;
                m_rom_v[m_ptr] <= 1'b1;
                m_ptr          <= (m_ptr + 1) % ROM_D;
                m_count        <= (m_count == 65535) ? 65535 : m_count + 1;
                if (load_last || m_ptr == ROM_D - 1) begin
                    m_loading <= 1'b0;
                    m_release <= cyc + 1 + HOLD;
                end
            end
            if (model_running() && writeM && int'(addressM) < RAM_D) begin
                m_ram[addressM]   <= outM;
                m_ram_v[addressM] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("load_ready", 16'(load_ready), 16'(m_loading));
            chk("cpu_reset", 16'(cpu_reset), 16'(!model_running()));
            chk("running", 16'(running), 16'(model_running()));
            chk("load_count", load_count, 16'(m_count));
            if (!model_running() || int'(pc) >= ROM_D)
                chk("instruction", instruction, 16'h0000);
            else if (m_rom_v[pc])
                chk("instruction", instruction, m_rom[pc]);
            if (int'(addressM) < RAM_D) begin
                if (m_ram_v[addressM]) chk("inM", inM, m_ram[addressM]);
            end else if (int'(addressM) == KBD_A)
                chk("inM", inM, kbd);
            else
                chk("inM", inM, 16'h0000);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic wait_running();
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (running) begin
                seen = 1'b1;
                break;
            end
        end
        chk("run_timeout", 16'(seen), 16'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prog [5];
        int n;
        int acc;
        bit ready_at4;
        prog[0] = 16'h000F; prog[1] = 16'hEC10; prog[2] = 16'h0014;
        prog[3] = 16'hE090; prog[4] = 16'hE308;

        reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        pc = '0; addressM = '0; outM = '0; writeM = 1'b0; kbd = '0;
        reset4 = 1'b1; load_valid4 = 1'b0; load_last4 = 1'b0; load_data4 = '0;
        tick(); tick();
        reset = 1'b0; reset4 = 1'b0;
        settle();
        chk("rst_load_ready", 16'(load_ready), 16'd1);
        chk("rst_cpu_reset", 16'(cpu_reset), 16'd1);
        chk("rst_running", 16'(running), 16'd0);
        chk("rst_load_count", load_count, 16'd0);

        // Five-word program, hold time, first fetch
        for (int i = 0; i < 5; i++) begin
            tick();
            load_valid = 1'b1; load_data = prog[i]; load_last = (i == 4);
        end
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) chk("load_count_5", load_count, 16'd5);
            if (!cpu_reset) break;
            n++;
        end
        chk("hold_cycles", 16'(n), 16'd4);
        chk("running_after_hold", 16'(running), 16'd1);
        tick(); pc = 15'd0;
        settle();
        chk("fetch_pc0", instruction, 16'h000F);

        // RAM write, read-during-write, keyboard and unmapped space
        tick(); addressM = 15'd0; outM = 16'h0ABC; writeM = 1'b1;
        tick(); addressM = 15'd20; outM = 16'd7;
        tick(); outM = 16'd35;
        settle();
        chk("rdw_old", inM, 16'd7);
        tick(); writeM = 1'b0;
        settle();
        chk("ram20_new", inM, 16'd35);
        tick(); kbd = 16'h0041; addressM = 15'd24576; writeM = 1'b1; outM = 16'h1234;
        settle();
        chk("kbd_read", inM, 16'h0041);
        tick(); writeM = 1'b0; addressM = 15'd0;
        settle();
        chk("ram0_after_kbd_write", inM, 16'h0ABC);
        tick(); addressM = 15'd2048;
        settle();
        chk("unmapped_read", inM, 16'h0000);

        // Random CPU bus traffic in RUN
        for (int i = 0; i < 300; i++) begin
            tick();
            pc = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(0, 32767)) : 15'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0, 1, 2: addressM = 15'($urandom_range(0, 31));
                3:       addressM = 15'(RAM_D - 1);
                4:       addressM = 15'(RAM_D + $urandom_range(0, 100));
                default: addressM = 15'(KBD_A);
            endcase
            outM = 16'($urandom);
            kbd = 16'($urandom);
            writeM = ($urandom_range(0, 2) == 0) && (addressM != 15'd20);
            load_valid = $urandom_range(0, 1) == 1;
            load_data = 16'($urandom);
        end
        load_valid = 1'b0;

        // Reset lands on a RAM write: write dropped, sequencer back to LOAD
        tick(); addressM = 15'd20; outM = 16'hBEEF; writeM = 1'b1; reset = 1'b1;
        tick(); reset = 1'b0; writeM = 1'b0;
        settle();
        chk("midrun_reset_running", 16'(running), 16'd0);
        chk("midrun_reset_cpu_reset", 16'(cpu_reset), 16'd1);
        chk("midrun_reset_load_ready", 16'(load_ready), 16'd1);
        chk("midrun_reset_ram20", inM, 16'd35);

        // Gapped load: valid 1,0,0,1 with last on the second accept
        tick(); load_valid = 1'b1; load_data = 16'h1111; load_last = 1'b0;
        tick(); load_valid = 1'b0; load_data = 16'hBAD0; load_last = 1'b1;
        tick(); load_data = 16'hBAD1;
        tick(); load_valid = 1'b1; load_data = 16'h2222; load_last = 1'b1;
        tick(); load_valid = 1'b0; load_last = 1'b0;
        settle();
        chk("gap_load_count", load_count, 16'd2);
        wait_running();
        tick(); pc = 15'd0;
        settle(); chk("gap_pc0", instruction, 16'h1111);
        tick(); pc = 15'd1;
        settle(); chk("gap_pc1", instruction, 16'h2222);
        tick(); pc = 15'd2;
        settle(); chk("gap_pc2_stale", instruction, 16'h0014);

        // Reset in the same cycle as an accept at ptr 2
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; load_valid = 1'b1; load_data = 16'h5555; load_last = 1'b0;
        tick(); load_data = 16'h6666;
        tick(); load_data = 16'hDEAD; reset = 1'b1;
        tick(); reset = 1'b0; load_data = 16'h7777; load_last = 1'b1;
        tick(); load_valid = 1'b0; load_last = 1'b0;
        settle();
        chk("rst_accept_count", load_count, 16'd1);
        wait_running();
        tick(); pc = 15'd2;
        settle(); chk("rst_accept_pc2", instruction, 16'h0014);
        tick(); pc = 15'd0;
        settle(); chk("rst_accept_pc0", instruction, 16'h7777);
        tick(); pc = 15'd1;
        settle(); chk("rst_accept_pc1", instruction, 16'h6666);

        // Random load stream followed by random RUN traffic
        tick(); reset = 1'b1;
        tick(); reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            load_valid = $urandom_range(0, 1) == 1;
            load_data = 16'($urandom);
            load_last = $urandom_range(0, 7) == 0;
            tick();
        end
        load_valid = 1'b1; load_last = 1'b1; load_data = 16'($urandom);
        tick(); load_valid = 1'b0; load_last = 1'b0;
        wait_running();
        for (int i = 0; i < 200; i++) begin
            tick();
            pc = 15'($urandom_range(0, 63));
            addressM = 15'($urandom_range(0, 63));
            outM = 16'($urandom);
            writeM = $urandom_range(0, 1) == 1;
            load_valid = $urandom_range(0, 1) == 1;
        end
        writeM = 1'b0; load_valid = 1'b0;

        // Four-word ROM: truncation after the last slot
        tick(); reset4 = 1'b1;
        tick(); reset4 = 1'b0; load_valid4 = 1'b1; load_last4 = 1'b0;
        acc = 0; ready_at4 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            load_data4 = 16'hA000 + 16'(k);
            settle();
            if (load_ready4) acc++;
            if (k == 4) ready_at4 = load_ready4;
            tick();
        end
        load_valid4 = 1'b0;
        chk("trunc_accepts", 16'(acc), 16'd4);
        chk("trunc_ready_after4", 16'(ready_at4), 16'd0);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) chk("trunc_load_count", load_count4, 16'd4);
            if (running4) begin
                n = 1;
                break;
            end
        end
        chk("trunc_run_timeout", 16'(n), 16'd1);
        chk("trunc_cpu_reset", 16'(cpu_reset4), 16'd0);
        tick(); pc = 15'd5; addressM = 15'(KBD_A); kbd = 16'h0041;
        settle();
        chk("trunc_pc5", instruction4, 16'h0000);
        chk("trunc_kbd", inM4, 16'h0041);
        tick(); pc = 15'd3;
        settle();
        chk("trunc_pc3", instruction4, 16'hA003);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
